// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, default transform size and stage-width
// helper for the FFT address generator.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fft_state_t;

    localparam int unsigned FFT_LOG2N_DEFAULT = 5;

    // Width needed to hold stage indices 0..log2n-1, never less than one bit.
    function automatic int unsigned fft_stage_width(input int unsigned log2n);
        int unsigned w;
        w = $clog2(log2n);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/fft_addr_map.sv
// fft_addr_map: purely combinational mapping from butterfly index j and
// stage s to the operand pair and twiddle ROM address of a radix-2 FFT.
module fft_addr_map
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N_DEFAULT,
    parameter int unsigned SW    = fft_stage_width(LOG2N)
) (
    input  logic [LOG2N-2:0] j,
    input  logic [SW-1:0]    s,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);

    logic [LOG2N-1:0] j_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] lo;
    logic [SW-1:0]    tw_shift;

    // Insert a zero at bit position s of j to form the upper operand, set that
    // bit for the lower operand, and scale the in-group offset for the twiddle.
    always_comb begin
        j_ext    = {1'b0, j};
        span     = LOG2N'(1) << s;
        lo       = j_ext & (span - LOG2N'(1));
        // two-step left shift avoids overflowing s+1 when s is at its maximum
        addr_a   = (((j_ext >> s) << s) << 1) | lo;
        addr_b   = addr_a | span;
        tw_shift = SW'(LOG2N - 1) - s;
        tw_addr  = lo[LOG2N-2:0] << tw_shift;
    end

endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: sequences butterfly operand/twiddle addresses for one full
// radix-2 FFT sweep with a valid/ready handshake.
// Define FFT_ADDR_GEN_DIF_EN for decimation-in-frequency stage order
// (LOG2N-1 down to 0); the default is decimation-in-time (0 up to LOG2N-1).
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = FFT_LOG2N_DEFAULT,
    parameter int unsigned SW    = fft_stage_width(LOG2N)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic [SW-1:0]    stage,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-2:0] J_LAST = '1;
`ifdef FFT_ADDR_GEN_DIF_EN
    localparam logic [SW-1:0] STAGE_FIRST = SW'(LOG2N - 1);
    localparam logic [SW-1:0] STAGE_FINAL = '0;
`else
    localparam logic [SW-1:0] STAGE_FIRST = '0;
    localparam logic [SW-1:0] STAGE_FINAL = SW'(LOG2N - 1);
`endif

    fft_state_t       state;
    fft_state_t       state_nxt;
    logic [LOG2N-2:0] j;
    logic [LOG2N-2:0] j_nxt;
    logic [SW-1:0]    stage_nxt;
    logic             load;
    logic             last_q;
    logic [LOG2N-1:0] map_a;
    logic [LOG2N-1:0] map_b;
    logic [LOG2N-2:0] map_tw;

    // The map sees the *next* index so its result can be registered on the
    // same edge that advances the counters.
    fft_addr_map #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_map (
        .j       (j_nxt),
        .s       (stage_nxt),
        .addr_a  (map_a),
        .addr_b  (map_b),
        .tw_addr (map_tw)
    );

    // Next state, next (j, stage) and whether the output pair reloads.
    always_comb begin
        state_nxt = state;
        j_nxt     = j;
        stage_nxt = stage;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    j_nxt     = '0;
                    stage_nxt = STAGE_FIRST;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (ready) begin
                    if (last_q) begin
                        state_nxt = DONE;
                    end else begin
                        load  = 1'b1;
                        j_nxt = j + (LOG2N-1)'(1);
                        if (j == J_LAST) begin
`ifdef FFT_ADDR_GEN_DIF_EN
                            stage_nxt = stage - SW'(1);
`else
                            stage_nxt = stage + SW'(1);
`endif
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered pair outputs; clr aborts any sweep.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            j       <= '0;
            stage   <= '0;
            addr_a  <= '0;
            addr_b  <= '0;
            tw_addr <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                j       <= j_nxt;
                stage   <= stage_nxt;
                addr_a  <= map_a;
                addr_b  <= map_b;
                tw_addr <= map_tw;
                last_q  <= (j_nxt == J_LAST) && (stage_nxt == STAGE_FINAL);
            end else if (state_nxt != RUN) begin
                last_q <= 1'b0;
            end
        end
    end

    assign valid = (state == RUN);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign last  = last_q;

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 Parameter LOG2N, default 5, meaning log2 of transform length N; legal range 2..12.
REQ-002 Parameter SW, default 3, meaning stage-index width; SW SHALL equal max(1, ceil(log2(LOG2N))).
REQ-003 clk  in  1  the block's single clock; all state changes on its rising edge.
REQ-004 clr  in  1  reset; asynchronous and active-high.
REQ-005 start  in  1  request one full FFT address sweep; sampled only in IDLE.
REQ-006 ready  in  1  downstream butterfly/memory accepts the current pair.
REQ-007 valid  out  1  addr_a, addr_b, tw_addr and stage are valid.
REQ-008 addr_a  out  LOG2N  upper butterfly operand address.
REQ-009 addr_b  out  LOG2N  lower butterfly operand address.
REQ-010 tw_addr  out  LOG2N-1  twiddle ROM address.
REQ-011 stage  out  SW  current stage index.
REQ-012 last  out  1  high with valid on the final pair of the sweep.
REQ-013 busy  out  1  high in RUN and DONE.
REQ-014 done  out  1  one-cycle pulse after the final transfer.

Function
REQ-015 FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE on transfer of the last pair; DONE->IDLE unconditionally after one cycle.
REQ-016 A transfer SHALL occur on any edge where valid and ready are both 1; valid SHALL be 1 exactly in RUN.
REQ-017 Latency: start sampled in IDLE at edge k SHALL give valid=1 with the first pair after edge k.
REQ-018 Butterfly counter j (LOG2N-1 bits) SHALL run from 0 to N/2-1 within a stage, advancing once per transfer.
REQ-019 At j wrap, j SHALL return to 0 and stage SHALL advance; the sweep SHALL be LOG2N stages, totalling LOG2N*N/2 transfers.
REQ-020 With span 2^s for stage s: addr_a = ((j>>s)<<(s+1)) | (j & (2^s-1)); addr_b = addr_a | 2^s; tw_addr = (j & (2^s-1)) << (LOG2N-1-s), all modulo their port widths.
REQ-021 While valid=1 and ready=0, all outputs SHALL hold stable.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing.
REQ-023 last SHALL be 1 only when j=N/2-1 and stage is the final stage.
REQ-024 done SHALL be 1 exactly in DONE; busy SHALL be 1 in RUN and DONE.

Reset
REQ-025 clr asserted SHALL immediately force IDLE, j=0, stage=0, and set valid, last, busy, done, addr_a, addr_b and tw_addr to 0, including mid-sweep.
REQ-026 After clr deassertion the block SHALL wait in IDLE for start; a sweep interrupted by clr SHALL NOT resume.

Configuration
REQ-027 Macro FFT_ADDR_GEN_DIF_EN SHALL select decimation-in-frequency order.
- Defined: stage runs LOG2N-1 down to 0.
- Undefined: stage runs 0 up to LOG2N-1 (decimation-in-time).
- Both cases: REQ-020 formulas and the last condition apply to the active stage value; last is on the final stage visited.

Structure
REQ-028 Package fft_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE), the default LOG2N, and the stage-width function used for SW.
REQ-029 Combinational sub-module fft_addr_map SHALL implement REQ-020 (inputs j and s; outputs addr_a, addr_b and tw_addr), and the top SHALL register its outputs.

Verification
REQ-030 LOG2N=3, ready=1, pulse start: stage0 pairs (0,1)(2,3)(4,5)(6,7) with tw=0. Stage2 pairs (0,4)(1,5)(2,6)(3,7) with tw=0,1,2,3. Total 12 transfers, last on the 12th, done one cycle later.
REQ-031 LOG2N=3, stage1: pairs (0,2)(1,3)(4,6)(5,7) with tw=0,2,0,2.
REQ-032 Drop ready for 3 cycles at transfer 5: outputs frozen, no pair skipped or repeated.
REQ-033 Assert clr at transfer 7: all outputs 0 immediately, IDLE. A new start then restarts at pair (0,1).
REQ-034 start held high through RUN and DONE: exactly one sweep, then a new sweep from IDLE.
REQ-035 With FFT_ADDR_GEN_DIF_EN and LOG2N=3: first pair (0,4) tw=0 at stage=2; last pair (6,7) at stage=0.
